mux_logic_unit: RTL and testbench
=================================

Name: mux_logic_unit

Overview:
- Parametrised, pipelined successor to the team's 2:1-mux gate cell.
- Every bit is built as a 2:1 mux selected by A[i], with data inputs drawn from {0, 1, B[i], ~B[i]}.
- Eight selectable logic functions on WIDTH-bit operands, with registered zero/parity flags and a saturating transfer counter.
- Sits between operand producers and consumers; valid/ready handshake on both sides; two-stage pipeline with full throughput.

Parameters:
- WIDTH, 8, operand/result bit width (>=1).
- CNT_W, 16, width of op_count (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept operand beat
- in_a  in  WIDTH  operand A; per-bit mux select
- in_b  in  WIDTH  operand B; feeds mux data inputs
- in_op  in  3  function select
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  result
- out_zero  out  1  1 when out_y == 0
- out_parity  out  1  XOR-reduction of out_y
- op_count  out  CNT_W  count of completed output transfers, saturating

Behaviour:
- Reset (rst_n low, async): s1_valid=0, s2_valid=0, out_valid=0, out_y=0, out_zero=0, out_parity=0, op_count=0. Takes effect immediately, including mid-transfer; in-flight beats are discarded. in_ready=1 once rst_n is high.
- Function per bit, y[i] = A[i] ? D1 : D0. (D0, D1) per in_op:
  - 000 AND (0, B)
  - 001 OR (B, 1)
  - 010 NAND (1, ~B)
  - 011 NOR (~B, 0)
  - 100 XOR (B, ~B)
  - 101 XNOR (~B, B)
  - 110 PASS_A (0, 1)
  - 111 NOT_A (1, 0)
- Stage 1: on in_valid && in_ready, register in_a, in_b, in_op and set s1_valid.
- Stage 2: on s1 advance, register y, zero=(y==0), parity=^y and set s2_valid. out_* are driven directly from the stage-2 registers.
- Advance rules:
  - s2 frees when !s2_valid || out_ready.
  - s1 advances when s1_valid && s2 frees.
  - in_ready = !s1_valid || s2 frees (combinational, no comb path from in_valid).
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, out_y, out_zero and out_parity hold stable. At most 2 beats are buffered, then in_ready=0.
- A simultaneous input accept and output transfer in the same cycle are both honoured; no bubble.
- Data is ordered strictly FIFO; no drops, no duplicates.
- op_count increments by 1 on each out_valid && out_ready and saturates at 2^CNT_W-1 (no wrap).
- in_op is sampled only at the input handshake; changes at other times have no effect.
- No X propagation: when valid is low, datapath registers may hold stale values, but out_* must never be X after reset.

Test Plan:
1. WIDTH=8, out_ready=1, A=8'hC5, B=8'hA3, in_op 0..7 on back-to-back cycles -> out_y sequence 81,E7,7E,18,66,99,C5,3A; first out_valid exactly 2 cycles after first accept; 8 consecutive valid cycles; op_count=8.
2. Flags: XOR A=FF,B=FF -> out_y=00, zero=1, parity=0; PASS_A A=07 -> out_y=07, zero=0, parity=1.
3. Backpressure: out_ready=0, offer 4 beats (op AND, A=F0,B=0F..0F+3) -> accepts 2 then in_ready=0; out_y holds 00 stable; release out_ready -> all 4 results delivered in order, no loss; op_count=4.
4. Random valid/ready toggling for 1000 beats vs reference model -> exact match, in-order, op_count=1000.
5. CNT_W=4, 20 transfers -> op_count climbs to 15 and stays 15.
6. Assert rst_n low asynchronously (mid-clock) with 2 beats in flight -> out_valid, out_y, op_count go 0 before the next edge; after release, in_ready=1 and a new beat completes in 2 cycles.

Source files
------------

// File: rtl/mux_logic_unit.sv
//------------------------------------------------------------------------------
// Module   : mux_logic_unit
// Brief    : Two-stage valid/ready pipeline; each result bit is a 2:1 mux on A[i].
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] c_op_and   = 3'd0;
  localparam logic [2:0] c_op_or    = 3'd1;
  localparam logic [2:0] c_op_nand  = 3'd2;
  localparam logic [2:0] c_op_nor   = 3'd3;
  localparam logic [2:0] c_op_xor   = 3'd4;
  localparam logic [2:0] c_op_xnor  = 3'd5;
  localparam logic [2:0] c_op_pass  = 3'd6;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_y;
  logic             r_s2_zero;
  logic             r_s2_parity;
  logic [CNT_W-1:0] r_op_count;

  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_in_acc;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_d0;
  logic [WIDTH-1:0] w_d1;
  logic [WIDTH-1:0] w_y;

  assign w_s2_free  = !r_s2_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign in_ready   = !r_s1_valid || w_s2_free;
  assign w_in_acc   = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;

  // Mux data inputs per function: y[i] = A[i] ? D1[i] : D0[i]
  always_comb begin
    w_d0 = '0;
    w_d1 = '0;
    case (r_s1_op)
      c_op_and:  begin w_d0 = '0;       w_d1 = r_s1_b;   end
      c_op_or:   begin w_d0 = r_s1_b;   w_d1 = '1;       end
      c_op_nand: begin w_d0 = '1;       w_d1 = ~r_s1_b;  end
      c_op_nor:  begin w_d0 = ~r_s1_b;  w_d1 = '0;       end
      c_op_xor:  begin w_d0 = r_s1_b;   w_d1 = ~r_s1_b;  end
      c_op_xnor: begin w_d0 = ~r_s1_b;  w_d1 = r_s1_b;   end
      c_op_pass: begin w_d0 = '0;       w_d1 = '1;       end
      default:   begin w_d0 = '1;       w_d1 = '0;       end
    endcase
  end

  assign w_y = (r_s1_a & w_d1) | (~r_s1_a & w_d0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else begin
      r_s1_valid <= w_in_acc || (r_s1_valid && !w_s1_adv);
      if (w_in_acc) begin
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
        r_s1_op <= in_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_y      <= '0;
      r_s2_zero   <= 1'b0;
      r_s2_parity <= 1'b0;
    end else begin
      r_s2_valid <= w_s1_adv || (r_s2_valid && !out_ready);
      if (w_s1_adv) begin
        r_s2_y      <= w_y;
        r_s2_zero   <= (w_y == '0);
        r_s2_parity <= ^w_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_out_xfer && (r_op_count != c_cnt_max)) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_y      = r_s2_y;
  assign out_zero   = r_s2_zero;
  assign out_parity = r_s2_parity;
  assign op_count   = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_mux_logic_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_logic_unit
// Brief    : Self-checking bench for mux_logic_unit against a boolean-function model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_logic_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_zero;
  logic         out_parity;
  logic [15:0]  op_count;

  logic         in_ready2;
  logic         out_valid2;
  logic [W-1:0] out_y2;
  logic         out_zero2;
  logic         out_parity2;
  logic [3:0]   op_count2;

  mux_logic_unit #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_parity(out_parity), .op_count(op_count)
  );

  mux_logic_unit #(.WIDTH(W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid2),
    .out_ready(out_ready), .out_y(out_y2), .out_zero(out_zero2),
    .out_parity(out_parity2), .op_count(op_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_y[$];
  logic         got_z[$];
  logic         got_p[$];
  int           got_c[$];
  int           model_cnt;
  int           model_cnt2;
  int           n_acc;
  int           n_out;
  int           cyc;
  int           first_acc;
  int           first_out;
  logic         prev_stall;
  logic [W-1:0] prev_y;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain boolean meaning of each function
  function automatic logic [W-1:0] ref_y(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  task automatic clear_model();
    exp_q.delete();
    got_y.delete();
    got_z.delete();
    got_p.delete();
    got_c.delete();
    model_cnt  = 0;
    model_cnt2 = 0;
    n_acc      = 0;
    n_out      = 0;
    first_acc  = -1;
    first_out  = -1;
    prev_stall = 1'b0;
    prev_y     = '0;
  endtask

  // Called at posedge+1 with inputs already driven; samples pre-edge, returns at next posedge+1.
  task automatic tick();
    logic [W-1:0] e;
    #2;
    if (prev_stall) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_y", {56'd0, out_y}, {56'd0, prev_y});
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_y(in_op, in_a, in_b));
      if (first_acc < 0) first_acc = cyc;
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("y", {56'd0, out_y}, {56'd0, e});
        check("zero", {63'd0, out_zero}, {63'd0, (e == '0)});
        check("parity", {63'd0, out_parity}, {63'd0, ^e});
      end
      got_y.push_back(out_y);
      got_z.push_back(out_zero);
      got_p.push_back(out_parity);
      got_c.push_back(cyc);
      if (first_out < 0) first_out = cyc;
      n_out++;
    end
    check("op_count", {48'd0, op_count}, 64'(model_cnt));
    check("op_count_sat", {60'd0, op_count2}, 64'(model_cnt2));
    prev_stall = out_valid && !out_ready;
    prev_y     = out_y;
    if (out_valid && out_ready && model_cnt < 65535) model_cnt++;
    if (out_valid2 && out_ready && model_cnt2 < 15) model_cnt2++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] seq [8];
    int guard;
    seq = '{8'h81, 8'hE7, 8'h7E, 8'h18, 8'h66, 8'h99, 8'hC5, 8'h3A};
    cyc   = 0;
    in_a  = '0;
    in_b  = '0;
    in_op = '0;
    #1;
    do_reset();

    // Reset state
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_y", {56'd0, out_y}, 64'd0);
    check("rst_zero", {63'd0, out_zero}, 64'd0);
    check("rst_parity", {63'd0, out_parity}, 64'd0);
    check("rst_op_count", {48'd0, op_count}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // All eight functions back to back
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_op    = 3'(i);
      in_a     = 8'hC5;
      in_b     = 8'hA3;
      tick();
    end
    in_valid = 1'b0;
    drain();
    check("t1_count", 64'(got_y.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_y.size(); i++)
      check("t1_seq", {56'd0, got_y[i]}, {56'd0, seq[i]});
    check("t1_latency", 64'(first_out - first_acc), 64'd2);
    if (got_c.size() == 8) check("t1_consecutive", 64'(got_c[7] - got_c[0]), 64'd7);
    check("t1_op_count", {48'd0, op_count}, 64'd8);

    // Flags
    do_reset();
    send(3'd4, 8'hFF, 8'hFF);
    send(3'd6, 8'h07, 8'h5A);
    drain();
    if (got_y.size() == 2) begin
      check("t2_xor_y", {56'd0, got_y[0]}, 64'h00);
      check("t2_xor_zero", {63'd0, got_z[0]}, 64'd1);
      check("t2_xor_par", {63'd0, got_p[0]}, 64'd0);
      check("t2_pass_y", {56'd0, got_y[1]}, 64'h07);
      check("t2_pass_zero", {63'd0, got_z[1]}, 64'd0);
      check("t2_pass_par", {63'd0, got_p[1]}, 64'd1);
    end else begin
      check("t2_count", 64'(got_y.size()), 64'd2);
    end

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_a     = 8'hF0;
      in_b     = 8'h0F + 8'(n_acc);
      tick();
    end
    check("t3_accepted", 64'(n_acc), 64'd2);
    check("t3_in_ready", {63'd0, in_ready}, 64'd0);
    check("t3_hold_y", {56'd0, out_y}, 64'h00);
    check("t3_out_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    guard = 0;
    while (n_acc < 4 && guard < 20) begin
      in_b = 8'h0F + 8'(n_acc);
      tick();
      guard++;
    end
    drain();
    check("t3_delivered", 64'(got_y.size()), 64'd4);
    if (got_y.size() == 4) begin
      check("t3_y0", {56'd0, got_y[0]}, 64'h00);
      check("t3_y1", {56'd0, got_y[1]}, 64'h10);
      check("t3_y3", {56'd0, got_y[3]}, 64'h10);
    end
    check("t3_op_count", {48'd0, op_count}, 64'd4);

    // Random valid/ready toggling, 1000 beats
    do_reset();
    guard = 0;
    while ((n_acc < 1000 || exp_q.size() != 0) && guard < 20000) begin
      in_valid  = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      guard++;
    end
    check("t4_beats_out", 64'(n_out), 64'd1000);
    check("t4_op_count", {48'd0, op_count}, 64'd1000);
    check("t4_sat_count", {60'd0, op_count2}, 64'd15);

    // Saturation with 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) send(3'd1, 8'(i), 8'h00);
    drain();
    check("t5_sat", {60'd0, op_count2}, 64'd15);
    check("t5_wide", {48'd0, op_count}, 64'd20);

    // Asynchronous reset mid-clock with two beats in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 3'd6;
      in_a     = 8'h11 + 8'(i);
      in_b     = 8'h00;
      tick();
    end
    in_valid = 1'b0;
    check("t6_pre_valid", {63'd0, out_valid}, 64'd1);
    check("t6_pre_count", {48'd0, op_count}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {63'd0, out_valid}, 64'd0);
    check("t6_async_y", {56'd0, out_y}, 64'd0);
    check("t6_async_count", {48'd0, op_count}, 64'd0);
    #1;
    rst_n = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    check("t6_in_ready", {63'd0, in_ready}, 64'd1);
    send(3'd7, 8'h3C, 8'h00);
    guard = 0;
    while (n_out == 0 && guard < 10) begin
      tick();
      guard++;
    end
    check("t6_latency", 64'(first_out - first_acc), 64'd2);
    if (got_y.size() > 0) check("t6_y", {56'd0, got_y[0]}, 64'hC3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
